// File: rtl/div_pkg.sv
// Shared types and bit-cell functions for the sequential approximate divider.
package div_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;
  localparam int CNT_W  = $clog2(DW_DEF - VW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row counter width for an arbitrary quotient width (at least one bit).
  function automatic int cnt_w(input int qw);
    return (qw > 1) ? $clog2(qw) : 1;
  endfunction

  // Full-subtractor borrow for a - b - bin.
  function automatic logic exact_bout(input logic a, input logic b, input logic bin);
    return (~a & bin) | (~a & b) | (b & bin);
  endfunction

  // Difference bit when the row subtracts, otherwise the restored dividend bit.
  function automatic logic exact_rout(input logic qs, input logic a, input logic b, input logic bin);
    return qs ? (a ^ b ^ bin) : a;
  endfunction

  // Approximate borrow ignores the dividend bit entirely.
  function automatic logic approx_bout(input logic b, input logic bin);
    return b | bin;
  endfunction

  // Approximate remainder bit: pass a on subtract, ~b on restore.
  function automatic logic approx_rout(input logic qs, input logic a, input logic b);
    return qs ? a : ~b;
  endfunction

endpackage

// File: rtl/approx_div_row.sv
// One combinational restoring-division row; the lowest n_approx cells use
// the approximate subtractor, the rest are exact.
module approx_div_row
  import div_pkg::*;
#(
  parameter int VW = 8,
  parameter int NW = $clog2(VW + 1)
) (
  input  logic [VW:0]   x,
  input  logic [VW-1:0] divisor,
  input  logic [NW-1:0] n_approx,
  output logic          qs,
  output logic [VW-1:0] rout
);

  logic [VW:0]   borrow;
  logic [VW-1:0] apx;

  // Ripple the borrow from LSB to MSB, picking the cell type per bit.
  always_comb begin
    borrow = '0;
    apx    = '0;
    for (int i = 0; i < VW; i++) begin
      apx[i]        = (NW'(i) < n_approx);
      borrow[i + 1] = apx[i] ? approx_bout(divisor[i], borrow[i])
                             : exact_bout(x[i], divisor[i], borrow[i]);
    end
  end

  // Extra top bit of x means the partial remainder already exceeds any divisor.
  assign qs = ~borrow[VW] | x[VW];

  // Select subtract-or-restore per cell once the quotient bit is known.
  always_comb begin
    rout = '0;
    for (int i = 0; i < VW; i++) begin
      rout[i] = apx[i] ? approx_rout(qs, x[i], divisor[i])
                       : exact_rout(qs, x[i], divisor[i], borrow[i]);
    end
  end

endmodule

// File: rtl/seq_approx_div.sv
// Iterative restoring divider: one quotient bit per clock, MSB first,
// with valid/ready on both sides and divide-by-zero / overflow flags.
module seq_approx_div
  import div_pkg::*;
#(
  parameter  int DW          = DW_DEF,
  parameter  int VW          = VW_DEF,
  parameter  int APPROX_BITS = 2,
  localparam int QW          = DW - VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  input  logic          approx_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output logic          ovf
);

  localparam int CW = (QW == DW_DEF - VW_DEF) ? CNT_W : cnt_w(QW);
  localparam int NW = $clog2(VW + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [VW-1:0] r_q;
  logic [VW-1:0] div_q;
  logic [QW-1:0] d_q;
  logic [QW-1:0] q_q;
  logic          apx_q;
  logic          dz_q;
  logic          ovf_q;

  logic [VW:0]   x_w;
  logic [NW-1:0] n_apx;
  logic          qs_w;
  logic [VW-1:0] rout_w;
  logic [QW-1:0] q_next;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign x_w      = {r_q, d_q[cnt]};
  assign q_next   = QW'({q_q, qs_w});

  // Row j approximates its lowest APPROX_BITS-j cells; none when exact mode.
  always_comb begin
    n_apx = '0;
    if (apx_q && (APPROX_BITS > int'(cnt)))
      n_apx = NW'(APPROX_BITS - int'(cnt));
  end

  approx_div_row #(.VW(VW), .NW(NW)) u_row (
    .x        (x_w),
    .divisor  (div_q),
    .n_approx (n_apx),
    .qs       (qs_w),
    .rout     (rout_w)
  );

  // Control FSM, iteration counter, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      r_q       <= '0;
      div_q     <= '0;
      d_q       <= '0;
      q_q       <= '0;
      apx_q     <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          if (dz_q) begin
            // Zero divisor: r_q was loaded with the dividend's low bits.
            quotient  <= '1;
            remainder <= r_q;
            dbz       <= 1'b1;
            ovf       <= ovf_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            r_q <= rout_w;
            q_q <= q_next;
            if (cnt == '0) begin
              quotient  <= q_next;
              remainder <= rout_w;
              dbz       <= 1'b0;
              ovf       <= ovf_q;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        IDLE, DONE: begin
          if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          // A retire and a new accept may land on the same edge.
          if (in_valid && in_ready) begin
            state <= BUSY;
            apx_q <= approx_en;
            div_q <= divisor;
            ovf_q <= (dividend[DW-1:QW] >= divisor);
            dz_q  <= (divisor == '0);
            d_q   <= dividend[QW-1:0];
            q_q   <= '0;
            if (divisor == '0) begin
              r_q <= dividend[VW-1:0];
              cnt <= '0;
            end else begin
              r_q <= dividend[DW-1:QW];
              cnt <= CW'(QW - 1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_approx_div.sv
// Self-checking bench for seq_approx_div: directed table, backpressure,
// reset abort and randomized traffic scored against an arithmetic model.
module tb_seq_approx_div;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int QW = DW - VW;
  localparam int AB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          approx_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [QW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;
  logic          ovf;

  always #5 clk = ~clk;

  seq_approx_div #(.DW(DW), .VW(VW), .APPROX_BITS(AB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  typedef struct {
    logic [QW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    logic          ovf;
  } exp_t;

  typedef struct {
    logic [DW-1:0] dd;
    logic [VW-1:0] dv;
    logic          apx;
    logic [QW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    logic          ovf;
    int            lat;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rnd_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic view of one row: approximate low cells OR the divisor bits
  // into a borrow, upper cells are a plain integer subtraction.
  function automatic exp_t model(input logic [DW-1:0] dd, input logic [VW-1:0] dv, input logic apx);
    exp_t e;
    logic [VW-1:0] r;
    logic [VW:0]   x;
    logic [VW-1:0] nr;
    int n, lo_b, hi_x, hi_d, hi_diff;
    logic bt, qs;
    e.ovf = (dd[DW-1:QW] >= dv);
    e.dbz = (dv == '0);
    e.q   = '0;
    e.r   = '0;
    if (dv == '0) begin
      e.q = '1;
      e.r = dd[VW-1:0];
      return e;
    end
    r = dd[DW-1:QW];
    for (int j = QW - 1; j >= 0; j--) begin
      x    = {r, dd[j]};
      n    = (apx && AB > j) ? AB - j : 0;
      lo_b = 0;
      for (int i = 0; i < n; i++) lo_b = lo_b | int'(dv[i]);
      hi_x    = int'(x[VW-1:0]) >> n;
      hi_d    = int'(dv) >> n;
      hi_diff = hi_x - hi_d - lo_b;
      bt      = (n >= VW) ? (lo_b != 0) : (hi_diff < 0);
      qs      = !bt || x[VW];
      nr      = qs ? VW'(hi_diff << n) : VW'(hi_x << n);
      for (int i = 0; i < n; i++) nr[i] = qs ? x[i] : ~dv[i];
      e.q[j] = qs;
      r      = nr;
    end
    e.r = r;
    return e;
  endfunction

  // Scoreboard: compare every retired result with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got q=%0d expected no result", quotient);
      end else begin
        e = sb.pop_front();
        check("sb_quotient", quotient, e.q);
        check("sb_remainder", remainder, e.r);
        check("sb_dbz", dbz, e.dbz);
        check("sb_ovf", ovf, e.ovf);
      end
    end
  end

  // Random consumer backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [DW-1:0] dd, input logic [VW-1:0] dv, input logic apx);
    bit ok = 1'b0;
    int guard = 0;
    in_valid  = 1'b1;
    dividend  = dd;
    divisor   = dv;
    approx_en = apx;
    while (!ok && guard < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        sb.push_back(model(dd, dv, apx));
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
  endtask

  // Counts clock edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid) return;
      @(posedge clk);
      lat++;
      if (lat > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL valid_timeout: got no out_valid expected within 50 cycles");
        return;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    int   lat;
    logic [DW-1:0] rdd;
    logic [VW-1:0] rdv;

    tbl[0] = '{16'd1000,  8'd7,   1'b0, 8'd142, 8'd6,   1'b0, 1'b0, 8};
    tbl[1] = '{16'd1000,  8'd7,   1'b1, 8'd142, 8'd4,   1'b0, 1'b0, 8};
    tbl[2] = '{16'd1000,  8'd0,   1'b0, 8'd255, 8'd232, 1'b1, 1'b1, 1};
    tbl[3] = '{16'h0800,  8'd8,   1'b0, 8'd255, 8'd8,   1'b0, 1'b1, 8};
    tbl[4] = '{16'd12345, 8'd100, 1'b0, 8'd123, 8'd45,  1'b0, 1'b0, 8};
    tbl[5] = '{16'd255,   8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 1'b0, 8};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", dbz, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int k = 0; k < 6; k++) begin
      send(tbl[k].dd, tbl[k].dv, tbl[k].apx);
      wait_valid(lat);
      check("tbl_latency", lat, tbl[k].lat);
      check("tbl_quotient", quotient, tbl[k].q);
      check("tbl_remainder", remainder, tbl[k].r);
      check("tbl_dbz", dbz, tbl[k].dbz);
      check("tbl_ovf", ovf, tbl[k].ovf);
      @(posedge clk);
      #1;
    end

    // Backpressure hold, then retire and accept on the same edge.
    out_ready = 1'b0;
    send(16'd1000, 8'd7, 1'b0);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_quotient", quotient, 142);
      check("hold_remainder", remainder, 6);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'd12345, 8'd100, 1'b0);
    wait_valid(lat);
    check("b2b_latency", lat, 8);
    check("b2b_quotient", quotient, 123);
    @(posedge clk);
    #1;

    // Reset in the middle of an operation.
    send(16'd1000, 8'd7, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_quotient", quotient, 0);
    sb.delete();
    @(negedge clk);
    check("abort_valid_hold", out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd1000, 8'd7, 1'b1);
    wait_valid(lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_quotient", quotient, 142);
    check("post_rst_remainder", remainder, 4);
    @(posedge clk);
    #1;

    // Random traffic in both modes with random backpressure.
    rnd_on = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      rdd = DW'($urandom());
      rdv = VW'($urandom());
      if ($urandom_range(0, 15) == 0) rdv = '0;
      if ($urandom_range(0, 3) == 0) rdd[DW-1:QW] = VW'($urandom_range(0, 3));
      send(rdd, rdv, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int g = 0; g < 100 && sb.size() != 0; g++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
